// File: rtl/jtag_bscan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_bscan_ctrl
// Brief    : IEEE 1149.1 TAP with IR, IDCODE, BYPASS and a boundary-scan
//            register (input/output cells) with a per-cell update stage.
// Revision : 1.0
// ============================================================================
module jtag_bscan_ctrl #(
    parameter int          IN_WIDTH   = 8,
    parameter int          OUT_WIDTH  = 8,
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                 tck,
    input  logic                 trst_n,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    output logic                 tdo_en,
    input  logic [IN_WIDTH-1:0]  pin_in,
    output logic [IN_WIDTH-1:0]  core_in,
    input  logic [OUT_WIDTH-1:0] core_out,
    output logic [OUT_WIDTH-1:0] pin_out,
    output logic [3:0]           tap_state,
    output logic [IR_WIDTH-1:0]  ir_out,
    output logic                 test_mode
);

    localparam int c_BSR_LEN = IN_WIDTH + OUT_WIDTH;

    localparam logic [3:0] c_EXIT2_DR   = 4'h0;
    localparam logic [3:0] c_EXIT1_DR   = 4'h1;
    localparam logic [3:0] c_SHIFT_DR   = 4'h2;
    localparam logic [3:0] c_PAUSE_DR   = 4'h3;
    localparam logic [3:0] c_SELECT_IR  = 4'h4;
    localparam logic [3:0] c_UPDATE_DR  = 4'h5;
    localparam logic [3:0] c_CAPTURE_DR = 4'h6;
    localparam logic [3:0] c_SELECT_DR  = 4'h7;
    localparam logic [3:0] c_EXIT2_IR   = 4'h8;
    localparam logic [3:0] c_EXIT1_IR   = 4'h9;
    localparam logic [3:0] c_SHIFT_IR   = 4'hA;
    localparam logic [3:0] c_PAUSE_IR   = 4'hB;
    localparam logic [3:0] c_RTI        = 4'hC;
    localparam logic [3:0] c_UPDATE_IR  = 4'hD;
    localparam logic [3:0] c_CAPTURE_IR = 4'hE;
    localparam logic [3:0] c_TLR        = 4'hF;

    localparam logic [IR_WIDTH-1:0] c_IR_EXTEST  = IR_WIDTH'(0);
    localparam logic [IR_WIDTH-1:0] c_IR_SAMPLE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] c_IR_IDCODE  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] c_IR_INTEST  = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = IR_WIDTH'(1);

    // ID register always reports a set LSB so a scan can tell it from BYPASS.
    localparam logic [31:0] c_IDCODE = {IDCODE_VAL[31:1], 1'b1};

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [IR_WIDTH-1:0]  r_ir_shift;
    logic [IR_WIDTH-1:0]  r_ir_active;
    logic [c_BSR_LEN-1:0] r_bsr;
    logic [c_BSR_LEN-1:0] r_upd;
    logic [31:0]          r_idreg;
    logic                 r_bypass;

    logic w_ir_extest;
    logic w_ir_sample;
    logic w_ir_idcode;
    logic w_ir_intest;
    logic w_sel_bsr;
    logic w_sel_id;
    logic w_sel_byp;
    logic w_enter_tlr;

    always_comb begin
        w_next = c_TLR;
        case (r_state)
            c_TLR:        w_next = tms ? c_TLR       : c_RTI;
            c_RTI:        w_next = tms ? c_SELECT_DR : c_RTI;
            c_SELECT_DR:  w_next = tms ? c_SELECT_IR : c_CAPTURE_DR;
            c_CAPTURE_DR: w_next = tms ? c_EXIT1_DR  : c_SHIFT_DR;
            c_SHIFT_DR:   w_next = tms ? c_EXIT1_DR  : c_SHIFT_DR;
            c_EXIT1_DR:   w_next = tms ? c_UPDATE_DR : c_PAUSE_DR;
            c_PAUSE_DR:   w_next = tms ? c_EXIT2_DR  : c_PAUSE_DR;
            c_EXIT2_DR:   w_next = tms ? c_UPDATE_DR : c_SHIFT_DR;
            c_UPDATE_DR:  w_next = tms ? c_SELECT_DR : c_RTI;
            c_SELECT_IR:  w_next = tms ? c_TLR       : c_CAPTURE_IR;
            c_CAPTURE_IR: w_next = tms ? c_EXIT1_IR  : c_SHIFT_IR;
            c_SHIFT_IR:   w_next = tms ? c_EXIT1_IR  : c_SHIFT_IR;
            c_EXIT1_IR:   w_next = tms ? c_UPDATE_IR : c_PAUSE_IR;
            c_PAUSE_IR:   w_next = tms ? c_EXIT2_IR  : c_PAUSE_IR;
            c_EXIT2_IR:   w_next = tms ? c_UPDATE_IR : c_SHIFT_IR;
            c_UPDATE_IR:  w_next = tms ? c_SELECT_DR : c_RTI;
            default:      w_next = c_TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_state <= c_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Entering (or remaining in) TLR via tms resets the same state trst_n does.
    assign w_enter_tlr = (w_next == c_TLR);

    assign w_ir_extest = (r_ir_active == c_IR_EXTEST);
    assign w_ir_sample = (r_ir_active == c_IR_SAMPLE);
    assign w_ir_idcode = (r_ir_active == c_IR_IDCODE);
    assign w_ir_intest = (r_ir_active == c_IR_INTEST);
    assign w_sel_bsr   = w_ir_extest | w_ir_sample | w_ir_intest;
    assign w_sel_id    = w_ir_idcode;
    assign w_sel_byp   = ~(w_sel_bsr | w_sel_id);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_shift  <= c_IR_CAPTURE;
            r_ir_active <= c_IR_IDCODE;
        end else if (w_enter_tlr) begin
            r_ir_shift  <= c_IR_CAPTURE;
            r_ir_active <= c_IR_IDCODE;
        end else begin
            case (r_state)
                c_CAPTURE_IR: r_ir_shift  <= c_IR_CAPTURE;
                c_SHIFT_IR:   r_ir_shift  <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
                c_UPDATE_IR:  r_ir_active <= r_ir_shift;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_bsr <= '0;
            r_upd <= '0;
        end else if (w_enter_tlr) begin
            r_bsr <= '0;
            r_upd <= '0;
        end else if (w_sel_bsr) begin
            case (r_state)
                c_CAPTURE_DR: r_bsr <= {core_out, pin_in};
                c_SHIFT_DR:   r_bsr <= {tdi, r_bsr[c_BSR_LEN-1:1]};
                c_UPDATE_DR:  r_upd <= r_bsr;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_idreg <= c_IDCODE;
        end else if (w_enter_tlr) begin
            r_idreg <= c_IDCODE;
        end else if (w_sel_id) begin
            if (r_state == c_CAPTURE_DR) begin
                r_idreg <= c_IDCODE;
            end else if (r_state == c_SHIFT_DR) begin
                r_idreg <= {tdi, r_idreg[31:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_bypass <= 1'b0;
        end else if (w_enter_tlr) begin
            r_bypass <= 1'b0;
        end else if (w_sel_byp) begin
            if (r_state == c_CAPTURE_DR) begin
                r_bypass <= 1'b0;
            end else if (r_state == c_SHIFT_DR) begin
                r_bypass <= tdi;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (r_state == c_SHIFT_IR) begin
            tdo = r_ir_shift[0];
        end else if (r_state == c_SHIFT_DR) begin
            if (w_sel_bsr) begin
                tdo = r_bsr[0];
            end else if (w_sel_id) begin
                tdo = r_idreg[0];
            end else begin
                tdo = r_bypass;
            end
        end
    end

    assign tdo_en    = (r_state == c_SHIFT_DR) || (r_state == c_SHIFT_IR);
    assign tap_state = r_state;
    assign ir_out    = r_ir_active;
    assign test_mode = w_ir_extest | w_ir_intest;

    assign core_in = w_ir_intest ? r_upd[IN_WIDTH-1:0] : pin_in;
    assign pin_out = (w_ir_extest | w_ir_intest) ? r_upd[c_BSR_LEN-1:IN_WIDTH] : core_out;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bscan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_bscan_ctrl
// Brief    : Directed, scoreboard-based bench for jtag_bscan_ctrl.
// Revision : 1.0
// ============================================================================
module tb_jtag_bscan_ctrl;

    localparam int IN_W  = 8;
    localparam int OUT_W = 8;
    localparam int IR_W  = 4;

    logic              tck;
    logic              trst_n;
    logic              tms;
    logic              tdi;
    logic              tdo;
    logic              tdo_en;
    logic [IN_W-1:0]   pin_in;
    logic [IN_W-1:0]   core_in;
    logic [OUT_W-1:0]  core_out;
    logic [OUT_W-1:0]  pin_out;
    logic [3:0]        tap_state;
    logic [IR_W-1:0]   ir_out;
    logic              test_mode;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_exp[$];

    jtag_bscan_ctrl #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .IR_WIDTH   (IR_W),
        .IDCODE_VAL (32'h1000_0001)
    ) dut (
        .tck       (tck),
        .trst_n    (trst_n),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .pin_in    (pin_in),
        .core_in   (core_in),
        .core_out  (core_out),
        .pin_out   (pin_out),
        .tap_state (tap_state),
        .ir_out    (ir_out),
        .test_mode (test_mode)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb_exp.push_back(v);
    endtask

    task automatic sb_pop_chk(input string tag, input logic [31:0] obs);
        if (sb_exp.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, sb_exp.pop_front());
        end
    endtask

    // Drive on the falling edge, sample tdo before the rising edge that shifts.
    task automatic tick(input logic t_ms, input logic t_di, output logic t_do);
        @(negedge tck);
        tms = t_ms;
        tdi = t_di;
        #1 t_do = tdo;
        @(posedge tck);
        #1;
    endtask

    task automatic nav(input logic t_ms);
        logic dummy;
        tick(t_ms, 1'b0, dummy);
    endtask

    // RTI -> IR scan -> RTI
    task automatic ir_scan(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
        logic b;
        cap = '0;
        nav(1'b1); nav(1'b1); nav(1'b0); nav(1'b0);
        for (int i = 0; i < IR_W; i++) begin
            tick(i == IR_W - 1, v[i], b);
            cap[i] = b;
        end
        nav(1'b1); nav(1'b0);
    endtask

    // RTI -> DR scan (optional pause after pause_at bits) -> RTI
    task automatic dr_scan(input int n, input logic [31:0] v, input int pause_at,
                           output logic [31:0] cap);
        logic b;
        cap = '0;
        nav(1'b1); nav(1'b0); nav(1'b0);
        chk("shift_dr_state", 32'(tap_state), 32'h2);
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i + 1 == pause_at), v[i], b);
            cap[i] = b;
            if ((i + 1 == pause_at) && (i != n - 1)) begin
                nav(1'b0);
                repeat (3) nav(1'b0);
                chk("pause_tdo_en", 32'(tdo_en), 32'h0);
                nav(1'b1); nav(1'b0);
            end
        end
        nav(1'b1); nav(1'b0);
    endtask

    initial begin
        logic [IR_W-1:0] ircap;
        logic [31:0]     drcap;

        trst_n   = 1'b0;
        tms      = 1'b1;
        tdi      = 1'b0;
        pin_in   = 8'h69;
        core_out = 8'h77;

        #12;
        chk("rst_tap_state", 32'(tap_state), 32'hF);
        chk("rst_ir_out",    32'(ir_out),    32'h2);
        chk("rst_tdo_en",    32'(tdo_en),    32'h0);
        chk("rst_tdo",       32'(tdo),       32'h0);
        chk("rst_test_mode", 32'(test_mode), 32'h0);
        chk("rst_pin_out",   32'(pin_out),   32'h77);
        chk("rst_core_in",   32'(core_in),   32'h69);

        @(negedge tck);
        trst_n = 1'b1;
        nav(1'b0);
        chk("rti_state", 32'(tap_state), 32'hC);

        // IDCODE straight after reset
        sb_push(32'h1000_0001);
        dr_scan(32, 32'h0, 0, drcap);
        sb_pop_chk("idcode_read", drcap);

        // IR capture pattern and load of all-ones (BYPASS)
        sb_push(32'h1);
        ir_scan(4'hF, ircap);
        sb_pop_chk("ir_capture", 32'(ircap));
        chk("ir_out_bypass", 32'(ir_out), 32'hF);

        // tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
        sb_push(32'h1A);
        dr_scan(5, 32'h0D, 0, drcap);
        sb_pop_chk("bypass_delay", drcap);

        ir_scan(4'h5, ircap);
        chk("ir_out_undef", 32'(ir_out), 32'h5);
        sb_push(32'h1A);
        dr_scan(5, 32'h0D, 0, drcap);
        sb_pop_chk("undef_bypass_delay", drcap);

        // SAMPLE/PRELOAD then EXTEST
        pin_in   = 8'h3C;
        core_out = 8'h00;
        ir_scan(4'h1, ircap);
        sb_push(32'h003C);
        dr_scan(16, 32'hA500, 0, drcap);
        sb_pop_chk("sample_capture", drcap);
        chk("sample_pin_out", 32'(pin_out), 32'h00);
        chk("sample_test_mode", 32'(test_mode), 32'h0);

        ir_scan(4'h0, ircap);
        chk("extest_pin_out",   32'(pin_out),   32'hA5);
        chk("extest_test_mode", 32'(test_mode), 32'h1);
        chk("extest_core_in",   32'(core_in),   32'h3C);

        core_out = 8'h81;
        sb_push(32'h813C);
        dr_scan(16, 32'h5A00, 0, drcap);
        sb_pop_chk("extest_capture", drcap);
        chk("extest_pin_out2", 32'(pin_out), 32'h5A);

        // INTEST
        pin_in   = 8'hC3;
        core_out = 8'h18;
        ir_scan(4'h1, ircap);
        chk("sample2_pin_out", 32'(pin_out), 32'h18);
        sb_push(32'h18C3);
        dr_scan(16, 32'h965A, 0, drcap);
        sb_pop_chk("sample2_capture", drcap);
        ir_scan(4'h3, ircap);
        chk("intest_ir_out",    32'(ir_out),    32'h3);
        chk("intest_core_in",   32'(core_in),   32'h5A);
        chk("intest_pin_out",   32'(pin_out),   32'h96);
        chk("intest_test_mode", 32'(test_mode), 32'h1);

        repeat (5) nav(1'b1);
        chk("tlr_tap_state", 32'(tap_state), 32'hF);
        chk("tlr_ir_out",    32'(ir_out),    32'h2);
        chk("tlr_core_in",   32'(core_in),   32'hC3);
        chk("tlr_pin_out",   32'(pin_out),   32'h18);
        chk("tlr_test_mode", 32'(test_mode), 32'h0);

        // IDCODE read with a pause in the middle of the scan
        nav(1'b0);
        sb_push(32'h1000_0001);
        dr_scan(32, 32'h0, 8, drcap);
        sb_pop_chk("idcode_pause", drcap);

        // EXTEST driving, then asynchronous reset mid-SHIFT_DR
        ir_scan(4'h1, ircap);
        sb_push(32'h18C3);
        dr_scan(16, 32'hA500, 0, drcap);
        sb_pop_chk("preload_capture", drcap);
        ir_scan(4'h0, ircap);
        chk("extest3_pin_out", 32'(pin_out), 32'hA5);

        nav(1'b1); nav(1'b0); nav(1'b0);
        repeat (3) nav(1'b0);
        chk("midscan_state", 32'(tap_state), 32'h2);
        #2 trst_n = 1'b0;
        #1;
        chk("midrst_tap_state", 32'(tap_state), 32'hF);
        chk("midrst_ir_out",    32'(ir_out),    32'h2);
        chk("midrst_tdo_en",    32'(tdo_en),    32'h0);
        chk("midrst_pin_out",   32'(pin_out),   32'h18);
        chk("midrst_core_in",   32'(core_in),   32'hC3);
        @(negedge tck);
        trst_n = 1'b1;

        nav(1'b0);
        chk("rti_again", 32'(tap_state), 32'hC);
        repeat (5) nav(1'b1);
        chk("tms_tlr", 32'(tap_state), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
